picorv32_mem_arbiter: RTL and testbench
=======================================

Name: picorv32_mem_arbiter

Overview:
- Two-master arbiter sharing one PicoRV32 native memory port (valid/ready, addr/wdata/wstrb/rdata, instr) between two requesters, e.g. two cores, or a core plus a DMA/debug master.
- Sits between the requesters and the single memory/bus slave.
- Round-robin grant; a grant is held until the slave completes the transfer.
- Downstream request fields are registered at grant time, so the slave sees stable, glitch-free signals.

Parameters:
- TIMEOUT_CYCLES, 255: slave cycles allowed before forced completion (used only with the optional feature); legal range 1..65535.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on a timed-out transfer (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction-fetch flag
- m0_ready  out  1  master 0 transfer complete
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_instr, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as master 0, for master 1
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream instruction flag
- mem_ready  in  1  downstream completion
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream byte strobes
- mem_rdata  in  32  downstream read data
- arb_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - grant=0, last_grant=1 (so master 0 wins the first tie), arb_timeout=0, timeout counter=0.
- State machine: IDLE, BUSY.
- IDLE:
  - Neither mX_valid high: stay IDLE.
  - Only one high: grant that master.
  - Both high: grant = ~last_grant.
  - On a grant: capture the granted master's addr/wdata/wstrb/instr into the mem_* registers, set mem_valid=1, last_grant=grant, go to BUSY.
  - mem_valid rises one cycle after the request is first seen.
- BUSY:
  - mem_* outputs are held constant.
  - On a cycle with mem_ready=1:
    - m<grant>_ready=1 combinationally in that cycle.
    - m<grant>_rdata = mem_rdata.
    - Next edge: mem_valid=0, state=IDLE.
- Ready qualification:
  - mX_ready = BUSY & mem_ready & (grant==X).
  - The non-granted master's ready is always 0.
  - mX_rdata is mem_rdata for both masters; meaningful only when mX_ready=1.
- Throughput: one IDLE bubble between transfers. Minimum 3 cycles per transfer from request to the next grant.
- Fairness:
  - With both masters continuously requesting, grants strictly alternate 0,1,0,1…
  - No master is starved for more than one transfer.
- mem_ready seen in IDLE: ignored; no mX_ready is produced.
- Requester protocol: a master holds valid and its fields stable until its ready. The arbiter does not re-sample fields while BUSY; changes are ignored.
- Reset asserted mid-transfer: all state clears immediately and mem_valid drops asynchronously. Any in-flight transfer is abandoned and no ready is generated.
- arb_timeout: cleared only by reset.

Optional Feature:
- Macro: PICORV32_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle with mem_ready=0.
  - When the counter equals TIMEOUT_CYCLES and mem_ready=0, that cycle:
    - m<grant>_ready=1 and m<grant>_rdata=ERR_RDATA.
    - arb_timeout is set.
    - Next edge: mem_valid=0, state=IDLE.
  - mem_ready arriving in the same cycle wins: normal completion, no flag.
- Not defined: no counter; arb_timeout is tied 0; BUSY waits indefinitely.

Test Plan:
- Single read: m0 requests addr=0x100, wstrb=0. mem_valid=1 next cycle with mem_addr=0x100, mem_instr=m0_instr. Slave gives mem_ready after 2 cycles with rdata=0x12345678. m0_ready=1 in that same cycle, m0_rdata=0x12345678, m1_ready=0.
- Simultaneous requests out of reset: m0 addr=0x0, m1 addr=0x4, wstrb=4'hF, wdata=0xA5A5A5A5. Master 0 is granted first, then master 1. mem_wstrb=4'hF and mem_wdata=0xA5A5A5A5 are seen during the master 1 grant.
- Continuous contention, 8 transfers with single-cycle ready: grant order 0,1,0,1,0,1,0,1, with exactly one idle cycle between transfers.
- Field stability: m0_addr changes 0x10→0x20 while BUSY. mem_addr stays 0x10 until completion.
- Reset mid-transfer: resetn driven low while BUSY. mem_valid=0 immediately with no edge needed. After release, an m1-only request is granted normally.
- With PICORV32_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: slave never readies. On the 5th BUSY cycle m0_ready=1, m0_rdata=0xFFFFFFFF and arb_timeout=1, and the flag stays 1 on subsequent normal transfers.

Source files
------------

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native memory port between two masters.
// Optional slave-timeout watchdog enabled by defining PICORV32_ARB_TIMEOUT_EN.
module picorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,

    output logic        arb_timeout
);
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_instr_q, mem_instr_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [SW-1:0] mem_wstrb_q, mem_wstrb_d;

    logic          grant_sel;
    logic          timeout_hit;
    logic          xfer_done;
    logic [DW-1:0] rdata_sel;

`ifdef PICORV32_ARB_TIMEOUT_EN
    localparam int unsigned CW = 16;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          arb_timeout_q, arb_timeout_d;

    assign timeout_hit = (state_q == S_BUSY) && !mem_ready && (cnt_q == CW'(TIMEOUT_CYCLES));
    assign rdata_sel   = timeout_hit ? ERR_RDATA : mem_rdata;

    // Counter sits at zero while idle, so it is clear on every BUSY entry.
    always_comb begin
        cnt_d         = cnt_q;
        arb_timeout_d = arb_timeout_q | timeout_hit;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (!mem_ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            arb_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            arb_timeout_q <= arb_timeout_d;
        end
    end

    assign arb_timeout = arb_timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{32'(TIMEOUT_CYCLES), ERR_RDATA};
    assign timeout_hit = 1'b0;
    assign rdata_sel   = mem_rdata;
    assign arb_timeout = 1'b0;
`endif

    // On a tie, the master that did not win last time gets the port.
    assign grant_sel = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
    assign xfer_done = (state_q == S_BUSY) && (mem_ready || timeout_hit);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_valid_d  = mem_valid_q;
        mem_instr_d  = mem_instr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    mem_valid_d  = 1'b1;
                    mem_instr_d  = grant_sel ? m1_instr : m0_instr;
                    mem_addr_d   = grant_sel ? m1_addr  : m0_addr;
                    mem_wdata_d  = grant_sel ? m1_wdata : m0_wdata;
                    mem_wstrb_d  = grant_sel ? m1_wstrb : m0_wstrb;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (xfer_done) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_valid_q  <= mem_valid_d;
            mem_instr_q  <= mem_instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    // Completion is passed straight back to the granted master in the same cycle.
    assign m0_ready  = xfer_done && !grant_q;
    assign m1_ready  = xfer_done &&  grant_q;
    assign m0_rdata  = rdata_sel;
    assign m1_rdata  = rdata_sel;

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Scoreboard bench for picorv32_mem_arbiter: directed stimulus queues expected grants/completions,
// an independent monitor checks every downstream request and every master ready.
`timescale 1ns/1ps
module tb_picorv32_mem_arbiter;
    localparam logic [31:0] KEY = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m0_instr = 1'b0, m0_ready;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
    logic [3:0]  m0_wstrb = '0;
    logic        m1_valid = 1'b0, m1_instr = 1'b0, m1_ready;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
    logic [3:0]  m1_wstrb = '0;
    logic        mem_valid, mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        arb_timeout;

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [31:0] rdata;
        bit          completes;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Slave model controls
    bit          slave_en = 1'b1;
    bit          slave_hang = 1'b0;
    int          slave_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] key = KEY;
    bit          chk_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, detail);
    endtask

    function automatic void push(input int m, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic ins, input logic [31:0] rd,
                                 input bit comp);
        exp_t e;
        e.m = m; e.addr = a; e.wdata = wd; e.wstrb = ws; e.instr = ins; e.rdata = rd; e.completes = comp;
        exp_q.push_back(e);
    endfunction

    // Slave: answers after slave_delay BUSY cycles with rdata = addr ^ key
    initial forever begin
        @(posedge clk); #1;
        if (slave_en) begin
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid && !slave_hang) begin
                if (wait_cnt >= slave_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr ^ key;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops an expectation on each new downstream request, checks fields and readies
    exp_t cur;
    bit   busy = 1'b0;
    logic prev_valid = 1'b0;
    int   gap = 0;
    initial forever begin
        @(negedge clk);
        if (mem_valid && !prev_valid) begin
            if (chk_gap) check("idle_gap", 32'(gap), 32'd1);
            if (busy && cur.completes) fail("missed_ready", $sformatf("got no ready expected ready for addr %h", cur.addr));
            if (exp_q.size() == 0) begin
                fail("unexpected_grant", $sformatf("got request addr %h expected none", mem_addr));
                busy = 1'b0;
            end else begin
                cur  = exp_q.pop_front();
                busy = 1'b1;
            end
        end
        if (mem_valid && busy) begin
            check("mem_addr", mem_addr, cur.addr);
            check("mem_wdata", mem_wdata, cur.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
            check("mem_instr", 32'(mem_instr), 32'(cur.instr));
        end
        if (m0_ready || m1_ready) begin
            if (m0_ready && m1_ready) begin
                fail("both_ready", "got m0_ready=1 m1_ready=1 expected one");
            end else if (!busy) begin
                fail("unexpected_ready", $sformatf("got m0=%b m1=%b expected none", m0_ready, m1_ready));
            end else begin
                check("ready_master", 32'(m1_ready), 32'(cur.m));
                check("rdata", m1_ready ? m1_rdata : m0_rdata, cur.rdata);
                if (!cur.completes) fail("abandoned_ready", "got ready expected none");
                busy = 1'b0;
            end
        end
        gap        = mem_valid ? 0 : gap + 1;
        prev_valid = mem_valid;
    end

    task automatic m_issue(input bit m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic ins);
        bit got = 1'b0;
        if (!m) begin
            m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = ins; m0_valid = 1'b1;
        end else begin
            m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = ins; m1_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m ? m1_ready : m0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("ready_wait", $sformatf("got no ready for m%0d expected ready", m));
        @(posedge clk); #1;
        if (!m) m0_valid = 1'b0; else m1_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n;

        // Reset values
        #12;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_instr", 32'(mem_instr), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_arb_timeout", 32'(arb_timeout), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Simultaneous requests out of reset: m0 first, then m1
        slave_delay = 1;
        push(0, 32'h0, 32'h0000_1111, 4'h3, 1'b0, 32'h0 ^ KEY, 1'b1);
        push(1, 32'h4, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h4 ^ KEY, 1'b1);
        fork
            m_issue(1'b0, 32'h0, 32'h0000_1111, 4'h3, 1'b0);
            m_issue(1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 1'b0);
        join

        // Single read with 2-cycle slave
        @(posedge clk); #1;
        slave_delay = 2;
        key = 32'h1234_5778;
        push(0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b1);
        m0_addr = 32'h100; m0_wdata = '0; m0_wstrb = '0; m0_instr = 1'b1; m0_valid = 1'b1;
        @(negedge clk);
        check("t1_mem_valid_pre", 32'(mem_valid), 32'd0);
        @(negedge clk);
        check("t1_mem_valid", 32'(mem_valid), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_instr", 32'(mem_instr), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m0_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (got) begin
            check("t1_m0_rdata", m0_rdata, 32'h1234_5678);
            check("t1_m1_ready", 32'(m1_ready), 32'd0);
        end else begin
            fail("t1_ready_wait", "got no m0_ready expected ready");
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        key = KEY;

        // Field stability while BUSY
        slave_delay = 3;
        push(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h10 ^ KEY, 1'b1);
        fork
            m_issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (mem_valid) break;
                end
                #1 m0_addr = 32'h20;
                repeat (2) begin
                    @(negedge clk);
                    check("stable_mem_addr", mem_addr, 32'h10);
                end
            end
        join

        // mem_ready while IDLE must not produce a ready
        @(posedge clk); #1;
        slave_en  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        repeat (3) begin
            @(negedge clk);
            check("idle_m0_ready", 32'(m0_ready), 32'd0);
            check("idle_m1_ready", 32'(m1_ready), 32'd0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        slave_en  = 1'b1;

        // Reset asserted mid-transfer
        slave_hang = 1'b1;
        push(0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        m0_addr = 32'h40; m0_wdata = '0; m0_wstrb = '0; m0_instr = 1'b0; m0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_valid) begin got = 1'b1; break; end
        end
        if (!got) fail("rst_busy_wait", "got no mem_valid expected request");
        #2 resetn = 1'b0;
        #1;
        check("midrst_mem_valid", 32'(mem_valid), 32'd0);
        check("midrst_m0_ready", 32'(m0_ready), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        m0_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        slave_hang = 1'b0;
        slave_delay = 0;
        push(1, 32'h80, 32'hCAFE_F00D, 4'h1, 1'b0, 32'h80 ^ KEY, 1'b1);
        m_issue(1'b1, 32'h80, 32'hCAFE_F00D, 4'h1, 1'b0);

        // Continuous contention, single-cycle ready: 0,1,0,1,...
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h200 + 32'(i * 8), 32'h0, 4'h0, 1'b0, (32'h200 + 32'(i * 8)) ^ KEY, 1'b1);
            push(1, 32'h300 + 32'(i * 8), 32'h0, 4'h0, 1'b1, (32'h300 + 32'(i * 8)) ^ KEY, 1'b1);
        end
        fork
            for (int i = 0; i < 4; i++) m_issue(1'b0, 32'h200 + 32'(i * 8), 32'h0, 4'h0, 1'b0);
            for (int j = 0; j < 4; j++) m_issue(1'b1, 32'h300 + 32'(j * 8), 32'h0, 4'h0, 1'b1);
            begin @(negedge m0_ready); chk_gap = 1'b1; end
        join
        chk_gap = 1'b0;

`ifdef PICORV32_ARB_TIMEOUT_EN
        // Slave never answers: forced completion on the 5th BUSY cycle
        @(posedge clk); #1;
        slave_hang = 1'b1;
        push(0, 32'h500, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        n = 0;
        fork
            m_issue(1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (mem_valid) n++;
                if (m0_ready) break;
            end
        join
        check("timeout_busy_cycles", 32'(n), 32'd5);
        check("timeout_flag", 32'(arb_timeout), 32'd1);
        slave_hang = 1'b0;
        push(1, 32'h600, 32'h0, 4'h0, 1'b0, 32'h600 ^ KEY, 1'b1);
        m_issue(1'b1, 32'h600, 32'h0, 4'h0, 1'b0);
        check("timeout_flag_sticky", 32'(arb_timeout), 32'd1);
`else
        n = 0;
        check("no_timeout_flag", 32'(arb_timeout) + 32'(n), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("leftover_expect", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
